// File: rtl/us_tx_pkg.sv
// ----------------------------------------------------------------------------
// us_tx_pkg
//   Shared types and default widths for the beamforming Transmitter frame
//   sequencer (scanline_sequencer and its listen/watchdog timer).
//   Contents:
//     DW_*_DEF     default widths for angle, r_0, num_points and listen counter
//     seq_state_t  sequencer FSM state encoding
// ----------------------------------------------------------------------------
package us_tx_pkg;

    localparam int DW_ANGLE_DEF  = 8;
    localparam int DW_INPUT_DEF  = 8;
    localparam int DW_POINTS_DEF = 13;
    localparam int DW_LISTEN_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIRE,
        WAIT_TX,
        LISTEN,
        NEXT
    } seq_state_t;

endpackage

// File: rtl/seq_listen_timer.sv
// ----------------------------------------------------------------------------
// seq_listen_timer
//   Loadable down-counter with a registered expiry pulse. After a load of V,
//   expire_o is high during the max(V,1)-th enabled cycle, so the owner can
//   treat it directly as "this is the last cycle of the interval".
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     load_i        load load_val_i (takes priority over counting)
//     load_val_i    interval length in cycles (0 behaves as 1)
//     en_i          count this cycle
//     expire_o      high during the last enabled cycle of the interval
// ----------------------------------------------------------------------------
module seq_listen_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         expire_q, expire_d;

    // The expiry flag is computed one cycle ahead: on load for 0/1-cycle
    // intervals, otherwise when the count passes through 2.
    always_comb begin
        cnt_d    = cnt_q;
        expire_d = 1'b0;
        if (load_i) begin
            cnt_d    = load_val_i;
            expire_d = (load_val_i <= W'(1));
        end else if (en_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - W'(1);
            end
            expire_d = (cnt_q == W'(2));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/scanline_sequencer.sv
// ----------------------------------------------------------------------------
// scanline_sequencer
//   Frame-level scheduler for the beamforming Transmitter. Sweeps the steering
//   angle from angle_start towards angle_stop in angle_step increments; for
//   each line it presents angle/r_0/num_points, pulses tx_initiate, waits for
//   tx_done, then holds a receive listen window.
//   Optional build macro: TX_TIMEOUT_EN adds a WAIT_TX watchdog that sets the
//   sticky error flag and returns to IDLE after TIMEOUT_CYCLES without tx_done.
//   Ports:
//     clk, rst                        clock, synchronous active-high reset
//     start, abort                    frame start pulse, abort level
//     angle_start/stop/step           sweep definition (latched on start)
//     r_0_cfg, num_points_cfg         per-line Transmitter settings
//     listen_cycles                   receive window after tx_done (0 = 1 cycle)
//     tx_done                         Transmitter line complete
//     tx_initiate, tx_angle,
//     tx_r_0, tx_num_points           Transmitter command interface
//     busy, line_idx                  status
//     line_done, frame_done           completion pulses
//     error                           sticky watchdog flag (0 without macro)
// ----------------------------------------------------------------------------
module scanline_sequencer
    import us_tx_pkg::*;
#(
    parameter int DW_ANGLE       = DW_ANGLE_DEF,
    parameter int DW_INPUT       = DW_INPUT_DEF,
    parameter int DW_POINTS      = DW_POINTS_DEF,
    parameter int DW_LISTEN      = DW_LISTEN_DEF,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DW_ANGLE-1:0]  angle_start,
    input  logic [DW_ANGLE-1:0]  angle_stop,
    input  logic [DW_ANGLE-1:0]  angle_step,
    input  logic [DW_INPUT-1:0]  r_0_cfg,
    input  logic [DW_POINTS-1:0] num_points_cfg,
    input  logic [DW_LISTEN-1:0] listen_cycles,
    input  logic                 tx_done,
    output logic                 tx_initiate,
    output logic [DW_ANGLE-1:0]  tx_angle,
    output logic [DW_INPUT-1:0]  tx_r_0,
    output logic [DW_POINTS-1:0] tx_num_points,
    output logic                 busy,
    output logic [DW_ANGLE-1:0]  line_idx,
    output logic                 line_done,
    output logic                 frame_done,
    output logic                 error
);

    seq_state_t           state_q;
    logic [DW_ANGLE-1:0]  ang_start_q, ang_stop_q, ang_step_q;
    logic [DW_INPUT-1:0]  r0_q;
    logic [DW_POINTS-1:0] np_q;
    logic [DW_LISTEN-1:0] listen_q;
    logic [DW_ANGLE-1:0]  tx_angle_q, line_idx_q;
    logic [DW_INPUT-1:0]  tx_r_0_q;
    logic [DW_POINTS-1:0] tx_num_points_q;
    logic                 tx_initiate_q, frame_done_q;
    logic                 lst_expire;

    // One extra bit so a step past the top of the angle range terminates the
    // frame instead of wrapping back to a small angle.
    logic [DW_ANGLE:0]    nxt;
    assign nxt = {1'b0, tx_angle_q} + {1'b0, ang_step_q};

    // Not loaded on an abort cycle so no stale expiry can leak out as line_done.
    seq_listen_timer #(.W(DW_LISTEN)) u_listen (
        .clk        (clk),
        .rst        (rst),
        .load_i     ((state_q == WAIT_TX) && tx_done && !abort),
        .load_val_i (listen_q),
        .en_i       (state_q == LISTEN),
        .expire_o   (lst_expire)
    );

`ifdef TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic wd_expire;
    logic error_q;

    // Armed in FIRE so it counts exactly the cycles spent in WAIT_TX.
    seq_listen_timer #(.W(WD_W)) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == FIRE),
        .load_val_i (WD_W'(TIMEOUT_CYCLES)),
        .en_i       (state_q == WAIT_TX),
        .expire_o   (wd_expire)
    );
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            ang_start_q     <= '0;
            ang_stop_q      <= '0;
            ang_step_q      <= '0;
            r0_q            <= '0;
            np_q            <= '0;
            listen_q        <= '0;
            tx_angle_q      <= '0;
            line_idx_q      <= '0;
            tx_r_0_q        <= '0;
            tx_num_points_q <= '0;
            tx_initiate_q   <= 1'b0;
            frame_done_q    <= 1'b0;
`ifdef TX_TIMEOUT_EN
            error_q         <= 1'b0;
`endif
        end else begin
            tx_initiate_q <= 1'b0;
            frame_done_q  <= 1'b0;
            if (abort && (state_q != IDLE)) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        // abort also blocks a start issued in the same cycle
                        if (start && !abort) begin
                            ang_start_q <= angle_start;
                            ang_stop_q  <= angle_stop;
                            ang_step_q  <= angle_step;
                            r0_q        <= r_0_cfg;
                            np_q        <= num_points_cfg;
                            listen_q    <= listen_cycles;
`ifdef TX_TIMEOUT_EN
                            error_q     <= 1'b0;
`endif
                            state_q     <= LOAD;
                        end
                    end
                    LOAD: begin
                        tx_angle_q      <= ang_start_q;
                        line_idx_q      <= '0;
                        tx_r_0_q        <= r0_q;
                        tx_num_points_q <= np_q;
                        tx_initiate_q   <= 1'b1;
                        state_q         <= FIRE;
                    end
                    FIRE: begin
                        state_q <= WAIT_TX;
                    end
                    WAIT_TX: begin
                        if (tx_done) begin
                            state_q <= LISTEN;
`ifdef TX_TIMEOUT_EN
                        end else if (wd_expire) begin
                            error_q <= 1'b1;
                            state_q <= IDLE;
`endif
                        end
                    end
                    LISTEN: begin
                        if (lst_expire) begin
                            state_q <= NEXT;
                        end
                    end
                    NEXT: begin
                        if ((ang_step_q == '0) || (nxt > {1'b0, ang_stop_q})) begin
                            frame_done_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            tx_angle_q    <= nxt[DW_ANGLE-1:0];
                            line_idx_q    <= line_idx_q + 1'b1;
                            tx_initiate_q <= 1'b1;
                            state_q       <= FIRE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tx_initiate   = tx_initiate_q;
    assign tx_angle      = tx_angle_q;
    assign tx_r_0        = tx_r_0_q;
    assign tx_num_points = tx_num_points_q;
    assign line_idx      = line_idx_q;
    assign busy          = (state_q != IDLE);
    assign line_done     = lst_expire && (state_q == LISTEN);
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_scanline_sequencer.sv
// ----------------------------------------------------------------------------
// tb_scanline_sequencer
//   Scoreboard bench: each directed frame pushes its expected event sequence
//   (initiate with angle/index, line_done, frame_done) into a queue; a monitor
//   pops and compares every time the DUT raises one of those pulses.
// ----------------------------------------------------------------------------
module tb_scanline_sequencer;

    localparam int K_INIT  = 0;
    localparam int K_LINE  = 1;
    localparam int K_FRAME = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  angle_start;
    logic [7:0]  angle_stop;
    logic [7:0]  angle_step;
    logic [7:0]  r_0_cfg;
    logic [12:0] num_points_cfg;
    logic [15:0] listen_cycles;
    logic        tx_done;
    logic        tx_initiate;
    logic [7:0]  tx_angle;
    logic [7:0]  tx_r_0;
    logic [12:0] tx_num_points;
    logic        busy;
    logic [7:0]  line_idx;
    logic        line_done;
    logic        frame_done;
    logic        error;

    typedef struct {
        int kind;
        int angle;
        int idx;
    } ev_t;

    ev_t expq[$];
    int  n_chk  = 0;
    int  n_pass = 0;
    int  cur_r0 = 0;
    int  cur_np = 0;
    bit  resp_en = 1'b1;

    scanline_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .angle_start    (angle_start),
        .angle_stop     (angle_stop),
        .angle_step     (angle_step),
        .r_0_cfg        (r_0_cfg),
        .num_points_cfg (num_points_cfg),
        .listen_cycles  (listen_cycles),
        .tx_done        (tx_done),
        .tx_initiate    (tx_initiate),
        .tx_angle       (tx_angle),
        .tx_r_0         (tx_r_0),
        .tx_num_points  (tx_num_points),
        .busy           (busy),
        .line_idx       (line_idx),
        .line_done      (line_done),
        .frame_done     (frame_done),
        .error          (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic push(input int kind, input int angle, input int idx);
        ev_t e;
        e.kind  = kind;
        e.angle = angle;
        e.idx   = idx;
        expq.push_back(e);
    endtask

    task automatic push_line(input int angle, input int idx);
        push(K_INIT, angle, idx);
        push(K_LINE, 0, 0);
    endtask

    task automatic ev_check(input int kind);
        ev_t e;
        if (expq.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_event: got kind %0d expected no event", kind);
        end else begin
            e = expq.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == K_INIT && e.kind == K_INIT) begin
                check("tx_angle", tx_angle, e.angle);
                check("line_idx", line_idx, e.idx);
                check("tx_r_0", tx_r_0, cur_r0);
                check("tx_num_points", tx_num_points, cur_np);
            end
        end
    endtask

    // Monitor: every DUT pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_initiate) ev_check(K_INIT);
            if (line_done)   ev_check(K_LINE);
            if (frame_done)  ev_check(K_FRAME);
        end
    end

    // Transmitter model: tx_done for one cycle, the cycle after each initiate.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_initiate && resp_en) begin
                @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    task automatic set_cfg(input int a0, input int a1, input int st,
                           input int r0, input int np, input int lc);
        angle_start    = 8'(a0);
        angle_stop     = 8'(a1);
        angle_step     = 8'(st);
        r_0_cfg        = 8'(r0);
        num_points_cfg = 13'(np);
        listen_cycles  = 16'(lc);
        cur_r0         = r0;
        cur_np         = np;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < maxc);
        if (busy) begin
            n_chk++;
            $display("FAIL %s_timeout: got busy after %0d cycles expected idle", nm, n);
        end
        @(negedge clk);
        check({nm, "_pending_events"}, expq.size(), 0);
    endtask

    task automatic wait_txdone(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_done && n < 50);
        if (!tx_done) begin
            n_chk++;
            $display("FAIL %s_txdone_timeout: got no tx_done expected tx_done", nm);
        end
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_tx_initiate", tx_initiate, 0);
        check("rst_tx_angle", tx_angle, 0);
        check("rst_line_idx", line_idx, 0);
        check("rst_line_done", line_done, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_error", error, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: 60..70 step 5, three lines
        set_cfg(60, 70, 5, 17, 1000, 3);
        push_line(60, 0);
        push_line(65, 1);
        push_line(70, 2);
        push(K_FRAME, 0, 0);
        pulse_start();
        wait_idle("sweep3", 200);
        check("sweep3_error", error, 0);

        // 2: wrap guard 250..255 step 10
        set_cfg(250, 255, 10, 3, 77, 2);
        push_line(250, 0);
        push(K_FRAME, 0, 0);
        pulse_start();
        wait_idle("wrap", 200);

        // 3a: zero step
        set_cfg(30, 90, 0, 9, 4095, 1);
        push_line(30, 0);
        push(K_FRAME, 0, 0);
        pulse_start();
        wait_idle("step0", 200);

        // 3b: start above stop
        set_cfg(80, 70, 5, 200, 8191, 0);
        push_line(80, 0);
        push(K_FRAME, 0, 0);
        pulse_start();
        wait_idle("start_gt_stop", 200);

        // abort and start together in IDLE: start ignored
        @(posedge clk);
        #1 begin start = 1'b1; abort = 1'b1; end
        @(posedge clk);
        #1 begin start = 1'b0; abort = 1'b0; end
        @(negedge clk);
        check("abort_start_idle_busy", busy, 0);

        // 4: abort during WAIT_TX
        resp_en = 1'b0;
        set_cfg(40, 50, 5, 5, 100, 4);
        push(K_INIT, 40, 0);
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_initiate && n < 20);
        check("abort_saw_initiate", tx_initiate, 1);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", busy, 0);
        @(posedge clk);
        #1 abort = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_pending_events", expq.size(), 0);
        resp_en = 1'b1;

        // new start accepted after abort
        set_cfg(10, 10, 1, 6, 12, 2);
        push_line(10, 0);
        push(K_FRAME, 0, 0);
        pulse_start();
        wait_idle("after_abort", 200);

        // 5: initiate latency, start ignored in LISTEN
        set_cfg(20, 25, 5, 11, 321, 5);
        push_line(20, 0);
        push_line(25, 1);
        push(K_FRAME, 0, 0);
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_initiate && n < 10);
        check("initiate_latency", n, 2);
        wait_txdone("listen_start");
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle("start_in_listen", 300);

        // 5b: listen_cycles = 0 -> line_done the cycle after tx_done
        set_cfg(33, 33, 1, 1, 2, 0);
        push_line(33, 0);
        push(K_FRAME, 0, 0);
        pulse_start();
        wait_txdone("listen0");
        @(negedge clk);
        check("listen0_line_done", line_done, 1);
        wait_idle("listen0", 200);

`ifdef TX_TIMEOUT_EN
        // 6: watchdog
        resp_en = 1'b0;
        set_cfg(50, 60, 5, 2, 3, 1);
        push(K_INIT, 50, 0);
        pulse_start();
        wait_idle("watchdog", 5000);
        check("watchdog_error", error, 1);
        resp_en = 1'b1;
        set_cfg(50, 60, 0, 2, 3, 1);
        push_line(50, 0);
        push(K_FRAME, 0, 0);
        pulse_start();
        @(negedge clk);
        check("watchdog_error_cleared", error, 0);
        wait_idle("after_watchdog", 200);
`else
        check("no_watchdog_error", error, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
